// File: rtl/stopwatch_uart_reporter_pkg.sv
// Shared constants and types for the stopwatch UART reporter: ASCII bytes,
// FSM encoding, frame length and the centisecond display ceiling.
package stopwatch_uart_reporter_pkg;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  // Four BCD digits cap the display at 99.99 s.
  localparam int unsigned MAX_CS = 9999;
  localparam int          BCD_W  = 16;
  localparam int          IDX_W  = 3;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    SEND,
    DONE
  } state_t;

  function automatic logic [IDX_W-1:0] frame_len(input bit send_crlf);
    return send_crlf ? 3'd7 : 3'd5;
  endfunction

endpackage

// File: rtl/stopwatch_uart_reporter_bin2bcd_seq.sv
// Iterative double-dabble converter: one shift per cycle, CNT_W cycles per
// conversion. bin_in must be held stable while busy.
module bin2bcd_seq
  import stopwatch_uart_reporter_pkg::*;
#(
  parameter int CNT_W = 14
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CNT_W-1:0]     bin_in,
  output logic                 busy,
  output logic                 done,
  output logic [BCD_W-1:0]     bcd
);

  localparam int CW = $clog2(CNT_W + 1);

  logic [CW-1:0] shift_cnt;
  logic [CW-1:0] bit_idx;

  function automatic logic [BCD_W-1:0] add3_shift(input logic [BCD_W-1:0] v,
                                                  input logic b);
    logic [BCD_W-1:0] r;
    r = v;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
    end
    return {r[BCD_W-2:0], b};
  endfunction

  // Binary bits are consumed MSB first straight from the held input.
  assign bit_idx = CW'(CNT_W - 1) - shift_cnt;
  // High during the cycle whose closing edge performs the final shift.
  assign done    = busy && (shift_cnt == CW'(CNT_W - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      busy      <= 1'b0;
      shift_cnt <= '0;
    end else if (start) begin
      busy      <= 1'b1;
      shift_cnt <= '0;
    end else if (busy) begin
      shift_cnt <= shift_cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      bcd <= '0;
    end else if (busy) begin
      bcd <= add3_shift(bcd, bin_in[bit_idx]);
    end
  end

endmodule

// File: rtl/stopwatch_uart_reporter.sv
// Snapshots the stopwatch count on request, converts it to BCD and pushes the
// ASCII frame "SS.CC" (optionally followed by CR LF) into the UART TX FIFO.
module stopwatch_uart_reporter
  import stopwatch_uart_reporter_pkg::*;
#(
  parameter int         CNT_W     = 14,
  parameter logic [7:0] SEP_CHAR  = 8'h2E,
  parameter bit         SEND_CRLF = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             send_req,
  input  logic [CNT_W-1:0] count,
  input  logic             fifo_full,
  output logic             wr,
  output logic [7:0]       wr_data,
  output logic             busy,
  output logic             done
);

  localparam logic [IDX_W-1:0] LAST_IDX = frame_len(SEND_CRLF) - 1'b1;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] snapshot;
  logic [BCD_W-1:0] bcd;
  logic             cvt_start;
  logic             cvt_busy;
  logic             cvt_done;
  logic [7:0]       byte_sel;

  function automatic logic [CNT_W-1:0] sat_cs(input logic [CNT_W-1:0] c);
    if (32'(c) > MAX_CS) return CNT_W'(MAX_CS);
    return c;
  endfunction

  function automatic logic [7:0] ascii_digit(input logic [3:0] d);
    return ASCII_ZERO + {4'h0, d};
  endfunction

  // Converter starts on the same edge the snapshot is taken so the shifts
  // land on the following CNT_W edges.
  assign cvt_start = (state == IDLE) && send_req;

  bin2bcd_seq #(
    .CNT_W (CNT_W)
  ) u_bin2bcd (
    .clk    (clk),
    .reset  (reset),
    .start  (cvt_start),
    .bin_in (snapshot),
    .busy   (cvt_busy),
    .done   (cvt_done),
    .bcd    (bcd)
  );

  always_comb begin
    byte_sel = 8'h00;
    case (idx)
      3'd0:    byte_sel = ascii_digit(bcd[15:12]);
      3'd1:    byte_sel = ascii_digit(bcd[11:8]);
      3'd2:    byte_sel = SEP_CHAR;
      3'd3:    byte_sel = ascii_digit(bcd[7:4]);
      3'd4:    byte_sel = ascii_digit(bcd[3:0]);
      3'd5:    byte_sel = ASCII_CR;
      3'd6:    byte_sel = ASCII_LF;
      default: byte_sel = 8'h00;
    endcase
  end

  assign wr      = (state == SEND) && !fifo_full;
  assign wr_data = (state == SEND) ? byte_sel : 8'h00;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      snapshot <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (send_req) begin
            snapshot <= sat_cs(count);
            busy     <= 1'b1;
            state    <= CONV;
          end
        end
        CONV: begin
          if (cvt_done) begin
            idx   <= '0;
            state <= SEND;
          end else if (!cvt_busy) begin
            // Converter lost its run (cannot happen in normal flow): recover.
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        SEND: begin
          if (wr) begin
            if (idx == LAST_IDX) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          idx   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stopwatch_uart_reporter.sv
// Directed bench for stopwatch_uart_reporter: table of frames plus hand-written
// stall, re-request, reset-abort and short-frame sequences.
module tb_stopwatch_uart_reporter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        send_req0 = 1'b0;
  logic        send_req1 = 1'b0;
  logic        fifo_full = 1'b0;
  logic [13:0] count = '0;

  logic        wr0, busy0, done0;
  logic [7:0]  wd0;
  logic        wr1, busy1, done1;
  logic [7:0]  wd1;

  stopwatch_uart_reporter #(
    .CNT_W(14), .SEP_CHAR(8'h2E), .SEND_CRLF(1'b1)
  ) dut0 (
    .clk(clk), .reset(reset), .send_req(send_req0), .count(count),
    .fifo_full(fifo_full), .wr(wr0), .wr_data(wd0), .busy(busy0), .done(done0)
  );

  stopwatch_uart_reporter #(
    .CNT_W(14), .SEP_CHAR(8'h2E), .SEND_CRLF(1'b0)
  ) dut1 (
    .clk(clk), .reset(reset), .send_req(send_req1), .count(count),
    .fifo_full(fifo_full), .wr(wr1), .wr_data(wd1), .busy(busy1), .done(done1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Capture of every written byte and every done pulse, stamped with the
  // number of rising edges seen so far.
  logic [7:0] bb [2][256];
  int         bc [2][256];
  int         dc [2][32];
  int         nb [2] = '{0, 0};
  int         nd [2] = '{0, 0};

  always @(negedge clk) begin
    if (wr0 && nb[0] < 256) begin
      bb[0][nb[0]] <= wd0;
      bc[0][nb[0]] <= cyc;
      nb[0]        <= nb[0] + 1;
    end
    if (done0 && nd[0] < 32) begin
      dc[0][nd[0]] <= cyc;
      nd[0]        <= nd[0] + 1;
    end
    if (wr1 && nb[1] < 256) begin
      bb[1][nb[1]] <= wd1;
      bc[1][nb[1]] <= cyc;
      nb[1]        <= nb[1] + 1;
    end
    if (done1 && nd[1] < 32) begin
      dc[1][nd[1]] <= cyc;
      nd[1]        <= nd[1] + 1;
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_until(input int e);
    while (cyc < e) step(1);
  endtask

  task automatic pulse(input int e, input int sel);
    wait_until(e - 1);
    if (sel == 1) send_req1 = 1'b1;
    else          send_req0 = 1'b1;
    step(1);
    send_req0 = 1'b0;
    send_req1 = 1'b0;
  endtask

  // Drives count and a one-cycle request; n is the edge that samples it.
  task automatic start_frame(input logic [13:0] c, input int sel, output int n);
    count = c;
    if (sel == 1) send_req1 = 1'b1;
    else          send_req0 = 1'b1;
    n = cyc + 1;
    step(1);
    send_req0 = 1'b0;
    send_req1 = 1'b0;
  endtask

  task automatic check_frame(input string nm, input int sel, input int b0,
                             input int d0, input logic [55:0] exp, input int len,
                             input int first_at, input int done_at);
    chk({nm, " nbytes"}, 0, nb[sel] - b0, len);
    for (int i = 0; i < len; i++) begin
      chk({nm, " byte"}, i,
          (b0 + i < nb[sel]) ? 32'(bb[sel][b0 + i]) : 32'hFFFF_FFFF,
          32'(exp[55 - 8*i -: 8]));
      if (first_at >= 0)
        chk({nm, " byte_cycle"}, i,
            (b0 + i < nb[sel]) ? bc[sel][b0 + i] : -1, first_at + i);
    end
    chk({nm, " ndone"}, 0, nd[sel] - d0, 1);
    chk({nm, " done_cycle"}, 0, (nd[sel] > d0) ? dc[sel][d0] : -1, done_at);
  endtask

  typedef struct {
    logic [13:0] cnt;
    logic [55:0] exp;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, b0, d0;

    vecs[0] = '{14'd1234,  56'h3132_2E33_340D_0A};
    vecs[1] = '{14'd0,     56'h3030_2E30_300D_0A};
    vecs[2] = '{14'd16383, 56'h3939_2E39_390D_0A};
    vecs[3] = '{14'd9999,  56'h3939_2E39_390D_0A};
    vecs[4] = '{14'd10000, 56'h3939_2E39_390D_0A};
    vecs[5] = '{14'd5,     56'h3030_2E30_350D_0A};

    step(3);
    chk("reset wr", 0, 32'(wr0), 0);
    chk("reset wr_data", 0, 32'(wd0), 0);
    chk("reset busy", 0, 32'(busy0), 0);
    chk("reset done", 0, 32'(done0), 0);
    reset = 1'b0;
    step(2);

    for (int v = 0; v < 6; v++) begin
      b0 = nb[0];
      d0 = nd[0];
      start_frame(vecs[v].cnt, 0, n);
      chk("busy after req", v, 32'(busy0), 1);
      step(30);
      check_frame("table", 0, b0, d0, vecs[v].exp, 7, n + 14, n + 21);
      chk("idle busy", v, 32'(busy0), 0);
    end

    // FIFO full for five cycles while the separator is pending.
    b0 = nb[0];
    d0 = nd[0];
    start_frame(14'd507, 0, n);
    wait_until(n + 16);
    fifo_full = 1'b1;
    step(2);
    chk("stall wr", 0, 32'(wr0), 0);
    chk("stall wr_data", 0, 32'(wd0), 32'h2E);
    chk("stall busy", 0, 32'(busy0), 1);
    step(3);
    fifo_full = 1'b0;
    step(20);
    check_frame("stall", 0, b0, d0, 56'h3035_2E30_370D_0A, 7, -1, n + 26);
    chk("stall cycle b1", 0, bc[0][b0 + 1], n + 15);
    chk("stall cycle b2", 0, bc[0][b0 + 2], n + 21);
    chk("stall cycle b6", 0, bc[0][b0 + 6], n + 25);

    // Re-requests during CONV, SEND and DONE plus a count change mid-frame.
    b0 = nb[0];
    d0 = nd[0];
    start_frame(14'd2468, 0, n);
    wait_until(n + 3);
    count = 14'd9;
    pulse(n + 5, 0);
    pulse(n + 16, 0);
    pulse(n + 22, 0);
    step(30);
    check_frame("rereq", 0, b0, d0, 56'h3234_2E36_380D_0A, 7, n + 14, n + 21);
    chk("rereq busy", 0, 32'(busy0), 0);

    // Reset while byte index 3 is on the bus.
    b0 = nb[0];
    d0 = nd[0];
    start_frame(14'd1234, 0, n);
    wait_until(n + 17);
    reset = 1'b1;
    step(1);
    chk("abort wr", 0, 32'(wr0), 0);
    chk("abort busy", 0, 32'(busy0), 0);
    reset = 1'b0;
    step(30);
    chk("abort nbytes", 0, nb[0] - b0, 4);
    chk("abort last byte", 0, 32'(bb[0][b0 + 3]), 32'h33);
    chk("abort ndone", 0, nd[0] - d0, 0);
    b0 = nb[0];
    d0 = nd[0];
    start_frame(14'd890, 0, n);
    step(30);
    check_frame("after abort", 0, b0, d0, 56'h3038_2E39_300D_0A, 7, n + 14, n + 21);

    // Short frame without CR LF.
    b0 = nb[1];
    d0 = nd[1];
    start_frame(14'd42, 1, n);
    step(30);
    check_frame("no crlf", 1, b0, d0, {40'h3030_2E34_32, 16'h0000}, 5, n + 14, n + 19);
    chk("no crlf busy", 0, 32'(busy1), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
